// File: rtl/cache_miss_pkg.sv
// Shared widths, FSM state encoding and word-address layout for the cache miss handler.
// Optional build macro used by the handler: CRITICAL_WORD_FIRST_EN.
package cache_miss_pkg;

  localparam int TAG_WIDTH    = 8;
  localparam int INDEX_WIDTH  = 6;
  localparam int OFFSET_WIDTH = 4;
  localparam int WAY_WIDTH    = 2;
  localparam int DATA_WIDTH   = 16;
  localparam int ADDR_WIDTH   = TAG_WIDTH + INDEX_WIDTH + OFFSET_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITEBACK,
    ST_FETCH,
    ST_UPDATE
  } miss_state_e;

  typedef struct packed {
    logic [TAG_WIDTH-1:0]    tag;
    logic [INDEX_WIDTH-1:0]  index;
    logic [OFFSET_WIDTH-1:0] offset;
  } mem_addr_t;

  function automatic mem_addr_t makeAddr(input logic [TAG_WIDTH-1:0]    tag,
                                         input logic [INDEX_WIDTH-1:0]  index,
                                         input logic [OFFSET_WIDTH-1:0] offset);
    mem_addr_t a;
    a.tag    = tag;
    a.index  = index;
    a.offset = offset;
    return a;
  endfunction

endpackage

// File: rtl/cache_miss_handler_if.sv
// Bundle of miss-request, data-array, tag/LRU update and memory-bus signals.
// The handler uses the slave modport; the cache controller / memory side uses master.
interface cache_miss_handler_if;
  import cache_miss_pkg::*;

  logic                    missValid;
  logic                    missReady;
  logic [TAG_WIDTH-1:0]    missTag;
  logic [INDEX_WIDTH-1:0]  missIndex;
  logic [OFFSET_WIDTH-1:0] missOffset;
  logic [WAY_WIDTH-1:0]    replacementCacheLine;
  logic                    victimValid;
  logic                    victimDirty;
  logic [TAG_WIDTH-1:0]    victimTag;
  logic [INDEX_WIDTH-1:0]  cacheIndex;
  logic [WAY_WIDTH-1:0]    cacheWay;
  logic [OFFSET_WIDTH-1:0] cacheOffset;
  logic [DATA_WIDTH-1:0]   cacheReadData;
  logic                    cacheWriteEnable;
  logic [DATA_WIDTH-1:0]   cacheWriteData;
  logic                    tagWriteEnable;
  logic [TAG_WIDTH-1:0]    tagOut;
  logic                    validOut;
  logic                    dirtyOut;
  logic                    lruAccessEnable;
  logic [INDEX_WIDTH-1:0]  lruIndex;
  logic [WAY_WIDTH-1:0]    lruLastAccessedCacheLine;
  logic                    memRead;
  logic                    memWrite;
  logic [ADDR_WIDTH-1:0]   memAddress;
  logic [DATA_WIDTH-1:0]   memDataOut;
  logic [DATA_WIDTH-1:0]   memDataIn;
  logic                    memAck;
  logic                    done;

  modport slave (
    input  missValid, missTag, missIndex, missOffset, replacementCacheLine,
           victimValid, victimDirty, victimTag, cacheReadData, memDataIn, memAck,
    output missReady, cacheIndex, cacheWay, cacheOffset, cacheWriteEnable, cacheWriteData,
           tagWriteEnable, tagOut, validOut, dirtyOut, lruAccessEnable, lruIndex,
           lruLastAccessedCacheLine, memRead, memWrite, memAddress, memDataOut, done
  );

  modport master (
    output missValid, missTag, missIndex, missOffset, replacementCacheLine,
           victimValid, victimDirty, victimTag, cacheReadData, memDataIn, memAck,
    input  missReady, cacheIndex, cacheWay, cacheOffset, cacheWriteEnable, cacheWriteData,
           tagWriteEnable, tagOut, validOut, dirtyOut, lruAccessEnable, lruIndex,
           lruLastAccessedCacheLine, memRead, memWrite, memAddress, memDataOut, done
  );

endinterface

// File: rtl/miss_word_counter.sv
// Block word counter: loadable start offset, wraps through the block, and flags the
// cycle in which the last of the 2**OFFSET_WIDTH acknowledged words is being transferred.
module miss_word_counter
  import cache_miss_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    i_load,
  input  logic [OFFSET_WIDTH-1:0] i_loadValue,
  input  logic                    i_inc,
  output logic [OFFSET_WIDTH-1:0] o_value,
  output logic                    o_lastWord
);

  logic [OFFSET_WIDTH-1:0] r_value;
  logic [OFFSET_WIDTH-1:0] r_seen;

  // r_seen counts acks independently of the (possibly non-zero) start offset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_value <= '0;
      r_seen  <= '0;
    end else if (i_load) begin
      r_value <= i_loadValue;
      r_seen  <= '0;
    end else if (i_inc) begin
      r_value <= r_value + 1'b1;
      r_seen  <= r_seen + 1'b1;
    end
  end

  assign o_value    = r_value;
  assign o_lastWord = &r_seen;

endmodule

// File: rtl/cache_miss_handler.sv
// Services one cache miss at a time: optional dirty write-back, block fetch, tag/LRU update.
// Define CRITICAL_WORD_FIRST_EN to start the fetch at the missing word instead of word 0.
module cache_miss_handler
  import cache_miss_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  cache_miss_handler_if.slave bus
);

  miss_state_e             r_state;
  logic                    r_memRead;
  logic                    r_memWrite;
  logic                    r_tagWrite;
  logic                    r_lruAccess;
  logic                    r_done;
  logic [TAG_WIDTH-1:0]    r_missTag;
  logic [TAG_WIDTH-1:0]    r_victimTag;
  logic [INDEX_WIDTH-1:0]  r_index;
  logic [WAY_WIDTH-1:0]    r_way;

  logic                    w_accept;
  logic                    w_dirtyVictim;
  logic                    w_ack;
  logic                    w_load;
  logic                    w_lastWord;
  logic [OFFSET_WIDTH-1:0] w_fetchStart;
  logic [OFFSET_WIDTH-1:0] w_loadValue;
  logic [OFFSET_WIDTH-1:0] w_count;
  mem_addr_t               w_addr;

  assign w_accept      = (r_state == ST_IDLE) && bus.missValid;
  assign w_dirtyVictim = bus.victimValid && bus.victimDirty;
  assign w_ack         = bus.memAck && (r_memRead || r_memWrite);

`ifdef CRITICAL_WORD_FIRST_EN
  logic [OFFSET_WIDTH-1:0] r_missOffset;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_missOffset <= '0;
    end else if (w_accept) begin
      r_missOffset <= bus.missOffset;
    end
  end

  assign w_fetchStart = r_memWrite ? r_missOffset : bus.missOffset;
`else
  assign w_fetchStart = '0;
`endif

  // Counter reloads on accept and again when the write-back hands over to the fetch.
  assign w_load      = w_accept || (r_memWrite && w_ack && w_lastWord);
  assign w_loadValue = (!r_memWrite && w_dirtyVictim) ? '0 : w_fetchStart;

  miss_word_counter u_counter (
    .clock       (clock),
    .reset       (reset),
    .i_load      (w_load),
    .i_loadValue (w_loadValue),
    .i_inc       (w_ack),
    .o_value     (w_count),
    .o_lastWord  (w_lastWord)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_memRead   <= 1'b0;
      r_memWrite  <= 1'b0;
      r_tagWrite  <= 1'b0;
      r_lruAccess <= 1'b0;
      r_done      <= 1'b0;
      r_missTag   <= '0;
      r_victimTag <= '0;
      r_index     <= '0;
      r_way       <= '0;
    end else begin
      r_tagWrite  <= 1'b0;
      r_lruAccess <= 1'b0;
      r_done      <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.missValid) begin
            r_missTag   <= bus.missTag;
            r_victimTag <= bus.victimTag;
            r_index     <= bus.missIndex;
            r_way       <= bus.replacementCacheLine;
            if (w_dirtyVictim) begin
              r_state    <= ST_WRITEBACK;
              r_memWrite <= 1'b1;
            end else begin
              r_state    <= ST_FETCH;
              r_memRead  <= 1'b1;
            end
          end
        end
        ST_WRITEBACK: begin
          if (bus.memAck && w_lastWord) begin
            r_state    <= ST_FETCH;
            r_memWrite <= 1'b0;
            r_memRead  <= 1'b1;
          end
        end
        ST_FETCH: begin
          if (bus.memAck && w_lastWord) begin
            r_state     <= ST_UPDATE;
            r_memRead   <= 1'b0;
            r_tagWrite  <= 1'b1;
            r_lruAccess <= 1'b1;
            r_done      <= 1'b1;
          end
        end
        ST_UPDATE: r_state <= ST_IDLE;
        default:   r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    w_addr = '0;
    if (r_memWrite) begin
      w_addr = makeAddr(r_victimTag, r_index, w_count);
    end else if (r_memRead) begin
      w_addr = makeAddr(r_missTag, r_index, w_count);
    end
  end

  assign bus.missReady                = (r_state == ST_IDLE);
  assign bus.cacheIndex               = r_index;
  assign bus.cacheWay                 = r_way;
  assign bus.cacheOffset              = w_count;
  assign bus.cacheWriteEnable         = r_memRead && bus.memAck;
  assign bus.cacheWriteData           = bus.memDataIn;
  assign bus.tagWriteEnable           = r_tagWrite;
  assign bus.tagOut                   = r_missTag;
  assign bus.validOut                 = r_tagWrite;
  assign bus.dirtyOut                 = 1'b0;
  assign bus.lruAccessEnable          = r_lruAccess;
  assign bus.lruIndex                 = r_index;
  assign bus.lruLastAccessedCacheLine = r_way;
  assign bus.memRead                  = r_memRead;
  assign bus.memWrite                 = r_memWrite;
  assign bus.memAddress               = w_addr;
  assign bus.memDataOut               = r_memWrite ? bus.cacheReadData : '0;
  assign bus.done                     = r_done;

endmodule

// File: tb/tb_cache_miss_handler.sv
// Bench for cache_miss_handler: scenario tasks compared against a block-level transfer model.
// Honours CRITICAL_WORD_FIRST_EN the same way the design does.
module tb_cache_miss_handler;
  import cache_miss_pkg::*;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

`ifdef CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   passCount = 0;
  int   checkCount = 0;

  always #5 clock = ~clock;

  cache_miss_handler_if bus();

  cache_miss_handler dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // The data array returns a word that encodes where it was read from.
  assign bus.cacheReadData = {bus.cacheWay, bus.cacheIndex, bus.cacheOffset, 4'h5} ^ 16'h3C96;

  addr_t            obsWb[$], obsRd[$], expWb[$], expRd[$];
  logic [15:0]      obsWbData[$], expWbData[$], obsCwData[$], sentCwData[$];
  logic [11:0]      obsCw[$], expCw[$];
  int               obsDoneCycle, obsReadyAtAccept, obsReadyAtDone, obsStableErr;
  int               obsBusyAccepts, obsTagWePulses, obsLruPulses;
  logic             obsTagWe, obsLruEn, obsValidOut, obsDirtyOut;
  logic [7:0]       obsTagOut;
  logic [5:0]       obsLruIndex;
  logic [1:0]       obsLruWay;

  function automatic logic [15:0] expData(input logic [1:0] way, input logic [5:0] index,
                                          input logic [3:0] off);
    return {way, index, off, 4'h5} ^ 16'h3C96;
  endfunction

  // Expected bus traffic of one miss, derived from block addresses and word order only.
  task automatic buildModel(input logic [7:0] tag, input logic [7:0] vTag, input logic [5:0] index,
                            input logic [3:0] offset, input logic [1:0] way, input bit dirtyVictim);
    int start;
    logic [3:0] o;
    expWb.delete(); expWbData.delete(); expRd.delete(); expCw.delete();
    if (dirtyVictim) begin
      for (int i = 0; i < 16; i++) begin
        o = i[3:0];
        expWb.push_back(addr_t'(int'(vTag) * 1024 + int'(index) * 16 + i));
        expWbData.push_back(expData(way, index, o));
      end
    end
    start = CWF ? int'(offset) : 0;
    for (int i = 0; i < 16; i++) begin
      o = 4'((start + i) % 16);
      expRd.push_back(addr_t'(int'(tag) * 1024 + int'(index) * 16 + int'(o)));
      expCw.push_back({index, way, o});
    end
  endtask

  // Drives one miss and records what the handler put on its outputs until done.
  task automatic doMiss(input logic [7:0] tag, input logic [7:0] vTag, input logic [5:0] index,
                        input logic [3:0] offset, input logic [1:0] way, input logic vValid,
                        input logic vDirty, input int ackEvery, input bit randomAck, input bit hold);
    int    cycle, ackCnt;
    logic  prevPending, prevRead;
    addr_t prevAddr;
    obsWb.delete(); obsRd.delete(); obsWbData.delete(); obsCw.delete();
    obsCwData.delete(); sentCwData.delete();
    obsDoneCycle = -1; obsStableErr = 0; obsBusyAccepts = 0;
    obsTagWePulses = 0; obsLruPulses = 0; obsReadyAtDone = -1;
    @(posedge clock); #1;
    bus.missValid = 1'b1; bus.missTag = tag; bus.missIndex = index; bus.missOffset = offset;
    bus.replacementCacheLine = way; bus.victimValid = vValid; bus.victimDirty = vDirty;
    bus.victimTag = vTag; bus.memAck = 1'b0;
    @(negedge clock);
    obsReadyAtAccept = int'(bus.missReady);
    cycle = 1; ackCnt = 0; prevPending = 1'b0; prevRead = 1'b0; prevAddr = '0;
    while (cycle < 150 && obsDoneCycle < 0) begin
      @(posedge clock); #1;
      if (!hold) bus.missValid = 1'b0;
      cycle++;
      bus.memAck = randomAck ? 1'($urandom_range(0, 1)) : ((ackCnt % ackEvery) == ackEvery - 1);
      ackCnt++;
      bus.memDataIn = 16'($urandom);
      @(negedge clock);
      if (bus.missValid && bus.missReady) obsBusyAccepts++;
      if (bus.tagWriteEnable) obsTagWePulses++;
      if (bus.lruAccessEnable) obsLruPulses++;
      if (bus.memWrite && bus.memAck) begin
        obsWb.push_back(bus.memAddress);
        obsWbData.push_back(bus.memDataOut);
      end
      if (bus.memRead && bus.memAck) obsRd.push_back(bus.memAddress);
      if (bus.cacheWriteEnable) begin
        obsCw.push_back({bus.cacheIndex, bus.cacheWay, bus.cacheOffset});
        obsCwData.push_back(bus.cacheWriteData);
        sentCwData.push_back(bus.memDataIn);
      end
      if (prevPending && (bus.memAddress !== prevAddr || bus.memRead !== prevRead ||
                          !(bus.memRead || bus.memWrite)))
        obsStableErr++;
      prevPending = (bus.memRead || bus.memWrite) && !bus.memAck;
      prevAddr = bus.memAddress;
      prevRead = bus.memRead;
      if (bus.done) begin
        obsDoneCycle = cycle; obsReadyAtDone = int'(bus.missReady);
        obsTagWe = bus.tagWriteEnable; obsLruEn = bus.lruAccessEnable;
        obsValidOut = bus.validOut; obsDirtyOut = bus.dirtyOut; obsTagOut = bus.tagOut;
        obsLruIndex = bus.lruIndex; obsLruWay = bus.lruLastAccessedCacheLine;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clock);
    checkCount++; if (bus.missReady !== 1'b1) $display("[TB] FAIL reset_missReady: got %b want 1", bus.missReady); else passCount++;
    checkCount++; if (bus.memRead !== 1'b0) $display("[TB] FAIL reset_memRead: got %b want 0", bus.memRead); else passCount++;
    checkCount++; if (bus.memWrite !== 1'b0) $display("[TB] FAIL reset_memWrite: got %b want 0", bus.memWrite); else passCount++;
    checkCount++; if (bus.done !== 1'b0) $display("[TB] FAIL reset_done: got %b want 0", bus.done); else passCount++;
    checkCount++; if (bus.tagWriteEnable !== 1'b0) $display("[TB] FAIL reset_tagWe: got %b want 0", bus.tagWriteEnable); else passCount++;
    checkCount++; if (bus.lruAccessEnable !== 1'b0) $display("[TB] FAIL reset_lruEn: got %b want 0", bus.lruAccessEnable); else passCount++;
    checkCount++; if (bus.memAddress !== '0) $display("[TB] FAIL reset_memAddress: got %h want 0", bus.memAddress); else passCount++;
    checkCount++; if (bus.tagOut !== '0) $display("[TB] FAIL reset_tagOut: got %h want 0", bus.tagOut); else passCount++;
    reset = 1'b1;
  endtask

  task automatic test_clean_miss();
    logic [3:0] off = 4'($urandom);
    logic [1:0] way = 2'($urandom);
    addr_t got;
    buildModel(8'h12, 8'h00, 6'd5, off, way, 1'b0);
    doMiss(8'h12, 8'h77, 6'd5, off, way, 1'($urandom), 1'b0, 1, 1'b0, 1'b0);
    checkCount++; if (obsReadyAtAccept != 1) $display("[TB] FAIL clean_ready: got %0d want 1", obsReadyAtAccept); else passCount++;
    checkCount++; if (obsDoneCycle != 18) $display("[TB] FAIL clean_done_cycle: got %0d want 18", obsDoneCycle); else passCount++;
    checkCount++; if (obsWb.size() != 0) $display("[TB] FAIL clean_wb_count: got %0d want 0", obsWb.size()); else passCount++;
    checkCount++; if (obsRd.size() != 16) $display("[TB] FAIL clean_rd_count: got %0d want 16", obsRd.size()); else passCount++;
    foreach (expRd[i]) begin
      got = (i < obsRd.size()) ? obsRd[i] : '1;
      checkCount++; if (got !== expRd[i]) $display("[TB] FAIL clean_rd_addr[%0d]: got %h want %h", i, got, expRd[i]); else passCount++;
    end
    checkCount++; if (obsCw.size() != 16) $display("[TB] FAIL clean_cw_count: got %0d want 16", obsCw.size()); else passCount++;
    foreach (expCw[i]) begin
      checkCount++;
      if (i >= obsCw.size() || obsCw[i] !== expCw[i] || obsCwData[i] !== sentCwData[i])
        $display("[TB] FAIL clean_cw[%0d]: got %h/%h want %h/%h", i,
                 (i < obsCw.size()) ? obsCw[i] : 12'hfff, (i < obsCw.size()) ? obsCwData[i] : 16'hffff,
                 expCw[i], (i < obsCw.size()) ? sentCwData[i] : 16'hffff);
      else passCount++;
    end
    checkCount++;
    if (obsTagWe !== 1'b1 || obsLruEn !== 1'b1 || obsValidOut !== 1'b1 || obsDirtyOut !== 1'b0)
      $display("[TB] FAIL clean_update_strobes: got tagWe=%b lru=%b valid=%b dirty=%b want 1 1 1 0",
               obsTagWe, obsLruEn, obsValidOut, obsDirtyOut);
    else passCount++;
    checkCount++;
    if (obsTagOut !== 8'h12 || obsLruIndex !== 6'd5 || obsLruWay !== way)
      $display("[TB] FAIL clean_update_fields: got tag=%h idx=%0d way=%0d want 12 5 %0d",
               obsTagOut, obsLruIndex, obsLruWay, way);
    else passCount++;
    checkCount++; if (obsTagWePulses != 1 || obsLruPulses != 1) $display("[TB] FAIL clean_pulse_count: got %0d/%0d want 1/1", obsTagWePulses, obsLruPulses); else passCount++;
  endtask

  task automatic test_dirty_miss();
    logic [7:0] tag = 8'($urandom);
    addr_t got;
    int bad = 0;
    buildModel(tag, 8'h34, 6'd5, 4'h3, 2'd2, 1'b1);
    doMiss(tag, 8'h34, 6'd5, 4'h3, 2'd2, 1'b1, 1'b1, 1, 1'b0, 1'b0);
    checkCount++; if (obsDoneCycle != 34) $display("[TB] FAIL dirty_done_cycle: got %0d want 34", obsDoneCycle); else passCount++;
    checkCount++; if (obsWb.size() != 16) $display("[TB] FAIL dirty_wb_count: got %0d want 16", obsWb.size()); else passCount++;
    foreach (expWb[i]) begin
      got = (i < obsWb.size()) ? obsWb[i] : '1;
      checkCount++; if (got !== expWb[i]) $display("[TB] FAIL dirty_wb_addr[%0d]: got %h want %h", i, got, expWb[i]); else passCount++;
      checkCount++;
      if (i >= obsWbData.size() || obsWbData[i] !== expWbData[i])
        $display("[TB] FAIL dirty_wb_data[%0d]: got %h want %h", i, (i < obsWbData.size()) ? obsWbData[i] : 16'hffff, expWbData[i]);
      else passCount++;
    end
    foreach (expRd[i]) if (i >= obsRd.size() || obsRd[i] !== expRd[i]) bad++;
    checkCount++; if (bad != 0 || obsRd.size() != 16) $display("[TB] FAIL dirty_rd_seq: got %0d bad of %0d want 0 of 16", bad, obsRd.size()); else passCount++;
  endtask

  task automatic test_slow_ack();
    logic dirty = 1'($urandom);
    int   words = dirty ? 32 : 16;
    buildModel(8'hC3, 8'h4E, 6'd33, 4'h6, 2'd1, dirty);
    doMiss(8'hC3, 8'h4E, 6'd33, 4'h6, 2'd1, 1'b1, dirty, 3, 1'b0, 1'b0);
    checkCount++; if (obsStableErr != 0) $display("[TB] FAIL slow_stable: got %0d changes want 0", obsStableErr); else passCount++;
    checkCount++; if (obsRd.size() != 16) $display("[TB] FAIL slow_rd_count: got %0d want 16", obsRd.size()); else passCount++;
    checkCount++; if (obsWb.size() != expWb.size()) $display("[TB] FAIL slow_wb_count: got %0d want %0d", obsWb.size(), expWb.size()); else passCount++;
    checkCount++; if (obsDoneCycle != 3 * words + 2) $display("[TB] FAIL slow_done_cycle: got %0d want %0d", obsDoneCycle, 3 * words + 2); else passCount++;
  endtask

  task automatic test_critical_word();
    logic [3:0] want = CWF ? 4'hA : 4'h0;
    addr_t first;
    int bad = 0;
    buildModel(8'h5A, 8'h00, 6'd9, 4'hA, 2'd1, 1'b0);
    doMiss(8'h5A, 8'h00, 6'd9, 4'hA, 2'd1, 1'b0, 1'b0, 1, 1'b0, 1'b0);
    first = (obsRd.size() > 0) ? obsRd[0] : '1;
    checkCount++; if (first[3:0] !== want) $display("[TB] FAIL cwf_first_word: got %h want %h", first[3:0], want); else passCount++;
    foreach (expRd[i]) if (i >= obsRd.size() || obsRd[i] !== expRd[i]) bad++;
    checkCount++; if (bad != 0 || obsRd.size() != 16) $display("[TB] FAIL cwf_order: got %0d bad of %0d want 0 of 16", bad, obsRd.size()); else passCount++;
  endtask

  task automatic test_reset_mid_fetch();
    int tagPulses = 0;
    @(posedge clock); #1;
    bus.missValid = 1'b1; bus.missTag = 8'h66; bus.missIndex = 6'd12; bus.missOffset = 4'h0;
    bus.replacementCacheLine = 2'd3; bus.victimValid = 1'b0; bus.victimDirty = 1'b0; bus.memAck = 1'b0;
    @(posedge clock); #1;
    bus.missValid = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.memAck = 1'b1;
      @(posedge clock); #1;
    end
    bus.memAck = 1'b0;
    @(negedge clock);
    checkCount++; if (bus.memRead !== 1'b1 || bus.cacheOffset !== 4'd7) $display("[TB] FAIL rst_mid_pre: got rd=%b off=%0d want 1 7", bus.memRead, bus.cacheOffset); else passCount++;
    #2 reset = 1'b0;
    #1;
    checkCount++; if (bus.memRead !== 1'b0) $display("[TB] FAIL rst_mid_memRead: got %b want 0", bus.memRead); else passCount++;
    checkCount++; if (bus.missReady !== 1'b1) $display("[TB] FAIL rst_mid_missReady: got %b want 1", bus.missReady); else passCount++;
    repeat (3) begin
      @(negedge clock);
      if (bus.tagWriteEnable || bus.done) tagPulses++;
    end
    reset = 1'b1;
    repeat (2) begin
      @(negedge clock);
      if (bus.tagWriteEnable || bus.done) tagPulses++;
    end
    checkCount++; if (tagPulses != 0) $display("[TB] FAIL rst_mid_no_tag_write: got %0d pulses want 0", tagPulses); else passCount++;
    checkCount++; if (bus.missReady !== 1'b1 || bus.memRead !== 1'b0) $display("[TB] FAIL rst_mid_idle: got ready=%b rd=%b want 1 0", bus.missReady, bus.memRead); else passCount++;
  endtask

  task automatic test_back_to_back();
    int n = 0;
    doMiss(8'h21, 8'h00, 6'd40, 4'h0, 2'd0, 1'b0, 1'b0, 1, 1'b0, 1'b1);
    checkCount++; if (obsBusyAccepts != 0) $display("[TB] FAIL b2b_busy_accepts: got %0d want 0", obsBusyAccepts); else passCount++;
    checkCount++; if (obsDoneCycle != 18 || obsReadyAtDone != 0) $display("[TB] FAIL b2b_first_done: got cycle=%0d ready=%0d want 18 0", obsDoneCycle, obsReadyAtDone); else passCount++;
    @(posedge clock); #1;
    bus.memAck = 1'b0;
    @(negedge clock);
    checkCount++; if (bus.missReady !== 1'b1) $display("[TB] FAIL b2b_ready_after_done: got %b want 1", bus.missReady); else passCount++;
    @(posedge clock); #1;
    bus.missValid = 1'b0;
    @(negedge clock);
    checkCount++; if (bus.memRead !== 1'b1 || bus.missReady !== 1'b0) $display("[TB] FAIL b2b_second_accept: got rd=%b ready=%b want 1 0", bus.memRead, bus.missReady); else passCount++;
    while (!bus.done && n < 100) begin
      @(posedge clock); #1;
      bus.memAck = 1'b1;
      @(negedge clock);
      n++;
    end
    checkCount++; if (bus.done !== 1'b1 || n != 17) $display("[TB] FAIL b2b_second_done: got done=%b after %0d want 1 after 17", bus.done, n); else passCount++;
    @(posedge clock); #1;
    bus.memAck = 1'b0;
  endtask

  task automatic test_random();
    for (int t = 0; t < 8; t++) begin
      logic [7:0] tag = 8'($urandom), vTag = 8'($urandom);
      logic [5:0] index = 6'($urandom);
      logic [3:0] off = 4'($urandom);
      logic [1:0] way = 2'($urandom);
      logic vValid = 1'($urandom), vDirty = 1'($urandom);
      int k = int'($urandom_range(1, 3));
      int words = (vValid && vDirty) ? 32 : 16;
      int bad = 0;
      buildModel(tag, vTag, index, off, way, vValid && vDirty);
      doMiss(tag, vTag, index, off, way, vValid, vDirty, k, 1'b0, 1'b0);
      foreach (expRd[i]) if (i >= obsRd.size() || obsRd[i] !== expRd[i]) bad++;
      foreach (expWb[i]) if (i >= obsWb.size() || obsWb[i] !== expWb[i] || obsWbData[i] !== expWbData[i]) bad++;
      foreach (expCw[i]) if (i >= obsCw.size() || obsCw[i] !== expCw[i] || obsCwData[i] !== sentCwData[i]) bad++;
      if (obsRd.size() != 16 || obsWb.size() != expWb.size() || obsCw.size() != 16) bad++;
      checkCount++; if (bad != 0) $display("[TB] FAIL rand%0d_traffic: got %0d bad items want 0", t, bad); else passCount++;
      checkCount++; if (obsDoneCycle != k * words + 2) $display("[TB] FAIL rand%0d_done_cycle: got %0d want %0d", t, obsDoneCycle, k * words + 2); else passCount++;
      checkCount++; if (obsStableErr != 0) $display("[TB] FAIL rand%0d_stable: got %0d want 0", t, obsStableErr); else passCount++;
    end
  endtask

  initial begin
    bus.missValid = 1'b0; bus.missTag = '0; bus.missIndex = '0; bus.missOffset = '0;
    bus.replacementCacheLine = '0; bus.victimValid = 1'b0; bus.victimDirty = 1'b0;
    bus.victimTag = '0; bus.memDataIn = '0; bus.memAck = 1'b0;
    $display("[TB] cache_miss_handler bench, critical word first = %0d", CWF);
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_slow_ack();
    test_critical_word();
    test_reset_mid_fetch();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
